// File: rtl/retire_map_unit_pkg.sv
// -----------------------------------------------------------------------------
// retire_map_unit_pkg
//   Shared types and sizes for the commit-side register map and free list.
//   phys_reg_t / arch_reg_t are the physical-tag and architectural-index types.
//   FREE_DEPTH is the number of tags not held by the committed map.
//   FPTR_W is the free-list pointer width, with one extra wrap bit.
// -----------------------------------------------------------------------------
package retire_map_unit_pkg;

  localparam int NUM_PHYS   = 64;
  localparam int NUM_ARCH   = 32;
  localparam int PW         = $clog2(NUM_PHYS);
  localparam int AW         = $clog2(NUM_ARCH);
  localparam int FREE_DEPTH = NUM_PHYS - NUM_ARCH;
  localparam int FPTR_W     = $clog2(FREE_DEPTH) + 1;

  typedef logic [PW-1:0]     phys_reg_t;
  typedef logic [AW-1:0]     arch_reg_t;
  typedef logic [FPTR_W-1:0] fptr_t;

  // Occupancy of a wrap-bit circular buffer: modular difference over full width.
  function automatic fptr_t ptr_count(input fptr_t tail, input fptr_t head);
    return tail - head;
  endfunction

endpackage

// File: rtl/retire_map_unit_phys_free_list.sv
// -----------------------------------------------------------------------------
// retire_map_unit_phys_free_list
//   Circular free list of physical tags. Pushes come from freeing commits,
//   pops from rename allocation. The speculative head moves on allocation.
//   Optional macro RMU_BRANCH_RECOVERY_EN adds an architectural head that moves
//   on each accepted push, and a flush input that rewinds the speculative head
//   onto it.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   push_i          recycle push_pd_i at the tail
//   push_pd_i       superseded physical tag
//   pop_i           rename consumes the tag at the speculative head
//   flush_i         (RMU_BRANCH_RECOVERY_EN only) rewind speculative head
//   alloc_valid_o   list non-empty
//   alloc_pd_o      tag at the speculative head
//   free_count_o    tail - spec_head
// -----------------------------------------------------------------------------
module retire_map_unit_phys_free_list
  import retire_map_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  phys_reg_t push_pd_i,
  input  logic      pop_i,
`ifdef RMU_BRANCH_RECOVERY_EN
  input  logic      flush_i,
`endif
  output logic      alloc_valid_o,
  output phys_reg_t alloc_pd_o,
  output fptr_t     free_count_o
);

  phys_reg_t list_q [FREE_DEPTH];
  fptr_t     tail_q, tail_d;
  fptr_t     spec_head_q, spec_head_d;
  fptr_t     count;
  logic      full;
  logic      push_ok;
  logic      pop_ok;
  logic      flush;

`ifdef RMU_BRANCH_RECOVERY_EN
  fptr_t     arch_head_q, arch_head_d;
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign count = ptr_count(tail_q, spec_head_q);
  // Full: same slot index, opposite lap.
  assign full  = (tail_q[FPTR_W-1] != spec_head_q[FPTR_W-1]) &&
                 (tail_q[FPTR_W-2:0] == spec_head_q[FPTR_W-2:0]);

  assign alloc_valid_o = (count != '0);
  assign alloc_pd_o    = list_q[spec_head_q[FPTR_W-2:0]];
  assign free_count_o  = count;

  // A push into a full list is dropped; allocation is blocked during flush.
  assign push_ok = push_i & ~full;
  assign pop_ok  = pop_i & alloc_valid_o & ~flush;

  always_comb begin
    tail_d      = tail_q + fptr_t'(push_ok);
    spec_head_d = spec_head_q + fptr_t'(pop_ok);
`ifdef RMU_BRANCH_RECOVERY_EN
    arch_head_d = arch_head_q + fptr_t'(push_ok);
    // Recovery point includes a freeing commit in the same cycle.
    if (flush) spec_head_d = arch_head_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tail_q      <= fptr_t'(FREE_DEPTH);
      spec_head_q <= '0;
`ifdef RMU_BRANCH_RECOVERY_EN
      arch_head_q <= '0;
`endif
      for (int k = 0; k < FREE_DEPTH; k++) begin
        list_q[k] <= phys_reg_t'(NUM_ARCH + k);
      end
    end else begin
      tail_q      <= tail_d;
      spec_head_q <= spec_head_d;
`ifdef RMU_BRANCH_RECOVERY_EN
      arch_head_q <= arch_head_d;
`endif
      if (push_ok) list_q[tail_q[FPTR_W-2:0]] <= push_pd_i;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(push_i && full));

endmodule

// File: rtl/retire_map_unit.sv
// -----------------------------------------------------------------------------
// retire_map_unit
//   Commit-side consumer of retired ROB entries. It holds the retirement
//   register file (committed arch->phys map). On a commit that writes a
//   non-zero rd, it recycles the superseded tag into the free list, which feeds
//   rename.
//   Optional macro RMU_BRANCH_RECOVERY_EN adds the flush port. In that build,
//   rrf_map shows the next-state map so that rename can reload its RAT in the
//   same cycle.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   commit_valid    ROB dequeue strobe
//   commit_we       retiring instruction writes rd
//   commit_rd       architectural destination
//   commit_pd       tag allocated to the retiring instruction
//   alloc_req       rename consumes one free tag
//   alloc_valid     free list non-empty
//   alloc_pd        tag offered to rename
//   free_count      number of free tags (0..FREE_DEPTH)
//   rrf_map         flattened map, entry i at [i*PW +: PW]
//   flush           (RMU_BRANCH_RECOVERY_EN only) mispredict recovery
// -----------------------------------------------------------------------------
module retire_map_unit
  import retire_map_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   commit_valid,
  input  logic                   commit_we,
  input  arch_reg_t              commit_rd,
  input  phys_reg_t              commit_pd,
  input  logic                   alloc_req,
  output logic                   alloc_valid,
  output phys_reg_t              alloc_pd,
  output logic [FPTR_W-1:0]      free_count,
`ifdef RMU_BRANCH_RECOVERY_EN
  input  logic                   flush,
`endif
  output logic [NUM_ARCH*PW-1:0] rrf_map
);

  phys_reg_t rrf_q [NUM_ARCH];
  phys_reg_t rrf_d [NUM_ARCH];
  logic      free_commit;
  phys_reg_t old_pd;

  // x0 and non-writing instructions never received a tag from rename.
  assign free_commit = commit_valid & commit_we & (commit_rd != '0);
  assign old_pd      = rrf_q[commit_rd];

  always_comb begin
    for (int i = 0; i < NUM_ARCH; i++) rrf_d[i] = rrf_q[i];
    if (free_commit) rrf_d[commit_rd] = commit_pd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) rrf_q[i] <= phys_reg_t'(i);
    end else begin
      for (int i = 0; i < NUM_ARCH; i++) rrf_q[i] <= rrf_d[i];
    end
  end

  for (genvar g = 0; g < NUM_ARCH; g++) begin : g_map
`ifdef RMU_BRANCH_RECOVERY_EN
    assign rrf_map[g*PW +: PW] = rrf_d[g];
`else
    assign rrf_map[g*PW +: PW] = rrf_q[g];
`endif
  end

  retire_map_unit_phys_free_list u_free_list (
    .clk           (clk),
    .rst           (rst),
    .push_i        (free_commit),
    .push_pd_i     (old_pd),
    .pop_i         (alloc_req),
`ifdef RMU_BRANCH_RECOVERY_EN
    .flush_i       (flush),
`endif
    .alloc_valid_o (alloc_valid),
    .alloc_pd_o    (alloc_pd),
    .free_count_o  (free_count)
  );

endmodule
